cybercobra_mc: RTL
==================

# cybercobra_mc

Multi-cycle, parametrised successor to the single-cycle CYBERcobra core. It executes the same 32-bit CYBERcobra instruction encoding, adding:
- an external instruction-memory request/acknowledge interface that tolerates wait states;
- a blocking input port with valid/ready handshake;
- a registered output with a strobe;
- a halt state.

It sits between the board-level memory/IO glue and the shared `alu_riscv` instance, and has its own internal 32x32 register file.

## Interface
- `RESET_PC`, default 32'h0, is the PC value loaded on reset.
- `SW_W`, default 16, is the width of `sw_i` (legal range 1..32). It is sign-extended to 32 bits.
- `clk_i`  in  1  is the single clock. Everything is rising-edge.
- `rst_i`  in  1  is the reset: synchronous, active-high.
- `sw_i`  in  SW_W  is the switch constant. It is sampled in EXEC.
- `imem_req_o`  out  1  is the fetch request.
- `imem_addr_o`  out  32  is the fetch address, equal to PC.
- `imem_ack_i`  in  1  is the fetch acknowledge. `imem_rdata_i` is valid in the same cycle.
- `imem_rdata_i`  in  32  is the instruction word.
- `in_valid_i`  in  1  means the input word is available.
- `in_data_i`  in  32  is the input word.
- `in_ready_o`  out  1  means the core is waiting for input.
- `out_o`  out  32  is the registered RD1 of the last executed instruction.
- `out_valid_o`  out  1  is a one-cycle strobe, high when `out_o` updates.
- `halted_o`  out  1  means the core is in HALT.
- `pc_o`  out  32  is the current PC, for debug.

## Operation
**Instruction fields (IR):**
- J = [31], B = [30], WS = [29:28], ALUop = [27:23], RA1 = [22:18], RA2 = [17:13].
- offset = [12:5], WA = [4:0].
- CONST = [27:5], sign-extended to 32 bits.

**Register file:**
- 32 x 32 bits, 2 combinational read ports, 1 synchronous write port.
- Reads of x0 return 0; writes to x0 are discarded.
- The RF array is not reset.

**ALU:** `alu_riscv` with a_i = RD1, b_i = RD2 and op = ALUop; it produces result and flag.

**FSM states:** FETCH, EXEC, WAIT_IN, HALT.
- **FETCH:**
  - `imem_req_o` = 1 and `imem_addr_o` = PC.
  - On a cycle with `imem_ack_i` = 1: IR <= `imem_rdata_i`, go to EXEC.
  - An ack while the request is low is ignored.
- **EXEC** (always exactly one cycle):
  - out_o <= RD1 and out_valid_o <= 1.
  - **Halt:** if J = 1 and offset = 0, go to HALT. PC is unchanged and there is no RF write.
  - **No write:** if J | B, there is no RF write. PC <= PC + sext({offset, 2'b00}) when J | (B & flag), else PC + 4. Go to FETCH.
  - **WS = 0:** RF[WA] <= sext(CONST).
  - **WS = 1:** RF[WA] <= ALU result.
  - **WS = 2:** RF[WA] <= sext(sw_i).
  - For WS = 0, 1 or 2: PC <= PC + 4, go to FETCH.
  - **WS = 3:** go to WAIT_IN. There is no write yet and PC is held.
- **WAIT_IN:**
  - `in_ready_o` = 1.
  - On a cycle with `in_valid_i` = 1: RF[WA] <= `in_data_i`, PC <= PC + 4, go to FETCH.
  - `in_ready_o` is 0 in every other state. A valid with ready low is not consumed.
- **HALT:** absorbing state. `halted_o` = 1, `imem_req_o` = 0, `in_ready_o` = 0. Only reset exits it.

**Arithmetic:** all PC arithmetic is 32-bit modulo 2^32. Wrap-around at 0xFFFFFFFC + 4 gives 0.

## Timing
**Reset:** at a clock edge where `rst_i` = 1, the core enters:
- state = FETCH and PC = RESET_PC;
- IR = 0, out_o = 0, out_valid_o = 0, halted_o = 0.

In the first cycle after reset, `imem_req_o` = 1.

**Reset mid-operation** (FETCH waiting on an ack, WAIT_IN, or HALT):
- the reset overrides the operation and the same values are loaded;
- a pending RF write in that cycle is suppressed;
- `rst_i` has priority over every other event.

**Fetch handshake:** while in FETCH, `imem_req_o` and `imem_addr_o` remain stable until the acknowledging edge. `imem_req_o` drops in the cycle after the ack, which is EXEC.

**Latency:**
- Minimum 2 cycles per instruction: ack in the first FETCH cycle, then EXEC.
- Each cycle the ack is delayed adds one cycle.
- A WS = 3 instruction adds at least one WAIT_IN cycle.

**Output strobe:** `out_valid_o` is high for exactly the cycle after each EXEC, including the halting EXEC.

**Write visibility:** an RF write performed at an edge is visible to reads in the next EXEC.

## Test plan
- **Reset:** hold rst_i for 2 cycles, then release. Required:
  - imem_req_o = 1, imem_addr_o = RESET_PC (0);
  - out_o = 0, halted_o = 0, in_ready_o = 0.
- **Fetch wait states and constant load:** ack the instruction WS = 0, CONST = 23'h400000, WA = 1 three cycles late. Required:
  - imem_addr_o stays 0 for all 4 request cycles;
  - x1 = 0xFFC00000;
  - next imem_addr_o = 4.
- **Taken branch:** x1 = x2 = 5, then at PC = 0x10 a B = 1 instruction with ALUop = equality and offset = 8'hFE. Required: next fetch at 0x08 and no RF write. With x2 = 6 the next fetch is at 0x14.
- **Input handshake:** a WS = 3, WA = 3 instruction with in_valid_i held low for 4 cycles. Required:
  - in_ready_o = 1 for those cycles and PC is unchanged;
  - then in_valid_i = 1 with 0xDEADBEEF gives x3 = 0xDEADBEEF;
  - in_ready_o = 0 next cycle and the next fetch is at PC + 4.
- **Switch sign-extension:** SW_W = 16, sw_i = 16'h8001, a WS = 2, WA = 4 instruction, then an instruction reading RA1 = 4. Required: x4 = 0xFFFF8001, and out_o = 0xFFFF8001 with out_valid_o pulsing once.
- **Halt:** J = 1 with offset = 0. Required:
  - halted_o = 1 and imem_req_o = 0 permanently;
  - a later acks and in_valid_i have no effect;
  - rst_i returns the core to FETCH at RESET_PC.

Source files
------------

// File: rtl/cybercobra_mc.sv
// Multi-cycle CYBERcobra core: handshaked instruction fetch, blocking input port,
// strobed registered output and a halt state. Also holds the shared RISC-V style ALU.

module alu_riscv (
  input  logic [4:0]  alu_op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] result_o,
  output logic        flag_o
);
  always_comb begin
    result_o = '0;
    flag_o   = 1'b0;
    case (alu_op_i)
      5'b00000: result_o = a_i + b_i;
      5'b01000: result_o = a_i - b_i;
      5'b00001: result_o = a_i << b_i[4:0];
      5'b00010: result_o = {31'b0, $signed(a_i) < $signed(b_i)};
      5'b00011: result_o = {31'b0, a_i < b_i};
      5'b00100: result_o = a_i ^ b_i;
      5'b00101: result_o = a_i >> b_i[4:0];
      5'b01101: result_o = $signed(a_i) >>> b_i[4:0];
      5'b00110: result_o = a_i | b_i;
      5'b00111: result_o = a_i & b_i;
      5'b11000: flag_o = (a_i == b_i);
      5'b11001: flag_o = (a_i != b_i);
      5'b11100: flag_o = $signed(a_i) < $signed(b_i);
      5'b11101: flag_o = $signed(a_i) >= $signed(b_i);
      5'b11110: flag_o = a_i < b_i;
      5'b11111: flag_o = a_i >= b_i;
      default:  result_o = '0;
    endcase
  end
endmodule

module cybercobra_mc #(
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter int unsigned SW_W     = 16
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [SW_W-1:0] sw_i,
  output logic            imem_req_o,
  output logic [31:0]     imem_addr_o,
  input  logic            imem_ack_i,
  input  logic [31:0]     imem_rdata_i,
  input  logic            in_valid_i,
  input  logic [31:0]     in_data_i,
  output logic            in_ready_o,
  output logic [31:0]     out_o,
  output logic            out_valid_o,
  output logic            halted_o,
  output logic [31:0]     pc_o
);
  typedef enum logic [1:0] {S_FETCH, S_EXEC, S_WAIT_IN, S_HALT} state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] ir;
  logic [31:0] rf_mem [32];

  logic        f_j, f_b;
  logic [1:0]  f_ws;
  logic [4:0]  f_op, f_ra1, f_ra2, f_wa;
  logic [7:0]  f_off;
  logic [31:0] const_ext, off_ext, sw_ext;
  logic [31:0] rd1, rd2, alu_res;
  logic        alu_flag;
  logic        rf_we;
  logic [31:0] rf_wd;

  assign f_j   = ir[31];
  assign f_b   = ir[30];
  assign f_ws  = ir[29:28];
  assign f_op  = ir[27:23];
  assign f_ra1 = ir[22:18];
  assign f_ra2 = ir[17:13];
  assign f_off = ir[12:5];
  assign f_wa  = ir[4:0];

  assign const_ext = {{9{ir[27]}}, ir[27:5]};
  assign off_ext   = {{22{f_off[7]}}, f_off, 2'b00};
  assign sw_ext    = 32'($signed(sw_i));

  assign rd1 = (f_ra1 == 5'd0) ? '0 : rf_mem[f_ra1];
  assign rd2 = (f_ra2 == 5'd0) ? '0 : rf_mem[f_ra2];

  alu_riscv u_alu (
    .alu_op_i (f_op),
    .a_i      (rd1),
    .b_i      (rd2),
    .result_o (alu_res),
    .flag_o   (alu_flag)
  );

  always_comb begin
    rf_we = 1'b0;
    rf_wd = '0;
    case (state)
      S_EXEC: begin
        if (!(f_j || f_b)) begin
          case (f_ws)
            2'd0:    begin rf_we = 1'b1; rf_wd = const_ext; end
            2'd1:    begin rf_we = 1'b1; rf_wd = alu_res;   end
            2'd2:    begin rf_we = 1'b1; rf_wd = sw_ext;    end
            default: rf_we = 1'b0;
          endcase
        end
      end
      S_WAIT_IN: begin
        rf_we = in_valid_i;
        rf_wd = in_data_i;
      end
      default: rf_we = 1'b0;
    endcase
  end

  // Register file is deliberately not reset; reset only masks a write in flight.
  always_ff @(posedge clk_i) begin
    if (!rst_i && rf_we && (f_wa != 5'd0))
      rf_mem[f_wa] <= rf_wd;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= S_FETCH;
      pc          <= RESET_PC;
      ir          <= '0;
      out_o       <= '0;
      out_valid_o <= 1'b0;
    end else begin
      out_valid_o <= 1'b0;
      case (state)
        S_FETCH: begin
          if (imem_ack_i) begin
            ir    <= imem_rdata_i;
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          out_o       <= rd1;
          out_valid_o <= 1'b1;
          if (f_j && (f_off == 8'd0)) begin
            state <= S_HALT;
          end else if (f_j || f_b) begin
            pc    <= (f_j || (f_b && alu_flag)) ? pc + off_ext : pc + 32'd4;
            state <= S_FETCH;
          end else if (f_ws == 2'd3) begin
            state <= S_WAIT_IN;
          end else begin
            pc    <= pc + 32'd4;
            state <= S_FETCH;
          end
        end
        S_WAIT_IN: begin
          if (in_valid_i) begin
            pc    <= pc + 32'd4;
            state <= S_FETCH;
          end
        end
        default: state <= S_HALT;
      endcase
    end
  end

  assign imem_req_o  = (state == S_FETCH);
  assign imem_addr_o = pc;
  assign in_ready_o  = (state == S_WAIT_IN);
  assign halted_o    = (state == S_HALT);
  assign pc_o        = pc;
endmodule
